folded_dot_product: RTL and testbench
=====================================

FOLDED_DOT_PRODUCT -- requirements
Module: folded_dot_product

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 256: elements per dot product; power of two, >= 2.
REQ-002 SHALL have parameter LANES, default 16: elements per input chunk; power of two, >= 2, divides VECTOR_SIZE.
REQ-003 SHALL have parameter J_ELEMENT_WIDTH, default 4: J element width.
REQ-004 SHALL have parameter J_SIGNED, default 0: 0 means J is an unsigned magnitude; 1 means J is two's complement.
REQ-005 SHALL have parameter PIPE_STAGE_MASK, default all zeros, width log2(LANES): bit i registers the output of lane-tree layer i.
REQ-006 SHALL have parameter RESULT_WIDTH, default (J_ELEMENT_WIDTH+1)+log2(VECTOR_SIZE): width of dot_out.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port flush, input, 1 bit: synchronous abort of the current vector.
REQ-010 SHALL have port in_valid, input, 1 bit: chunk valid.
REQ-011 SHALL have port in_ready, output, 1 bit: chunk accept.
REQ-012 SHALL have port sigma, input, LANES bits: 1 selects +J, 0 selects -J.
REQ-013 SHALL have port J_chunk, input, array [0:LANES-1] of J_ELEMENT_WIDTH bits: J elements.
REQ-014 SHALL have port res_valid, output, 1 bit: result valid.
REQ-015 SHALL have port res_ready, input, 1 bit: result accept.
REQ-016 SHALL have port dot_out, output, signed RESULT_WIDTH bits: dot product.
REQ-017 SHALL have port chunk_idx, output, log2(VECTOR_SIZE/LANES) bits: index of the next chunk expected.

Function
REQ-018 SHALL form each term in width W0 = J_ELEMENT_WIDTH+1 as ±ext(J), using zero-extension when J_SIGNED=0 and sign-extension when J_SIGNED=1; the -(-2^(Jw-1)) case SHALL be exact.
REQ-019 SHALL reduce the LANES terms through a pairwise tree that adds 1 bit per layer, giving an exact width of W0+log2(LANES).
REQ-020 SHALL give the tree a latency of P = popcount(PIPE_STAGE_MASK) cycles, with a valid bit travelling alongside each registered stage; the tree SHALL never stall.
REQ-021 SHALL sign-extend each tree output into an accumulator of W0+log2(VECTOR_SIZE) bits; exact arithmetic, no overflow or saturation.
REQ-022 SHALL implement an FSM with three states:
- ACCUM: in_ready=1.
- DRAIN: in_ready=0; waits for in-flight tree outputs.
- DONE: in_ready=0, res_valid=1.
REQ-023 SHALL treat a chunk as accepted when in_valid and in_ready are both 1 at a clk edge; chunk_idx then increments, wrapping to 0 after the last chunk.
REQ-024 SHALL, on acceptance of chunk VECTOR_SIZE/LANES-1, transition ACCUM to DRAIN when P>0, and ACCUM to DONE when P=0.
REQ-025 SHALL transition DRAIN to DONE on the edge where the last tree output is accumulated.
REQ-026 SHALL assert res_valid exactly P+1 cycles after the last chunk handshake.
REQ-027 SHALL, in DONE, hold dot_out stable until res_ready=1; on that edge it SHALL go to ACCUM with the accumulator at 0, so the next chunk is accepted no earlier than the following cycle.
REQ-028 SHALL drive dot_out equal to the accumulator sign-extended or truncated to RESULT_WIDTH; when RESULT_WIDTH is below the required width, simulation SHALL $error.
REQ-029 SHALL, when flush=1 at an edge in any state, clear the accumulator, chunk_idx, all tree valid bits and res_valid, and go to ACCUM; flush SHALL override a simultaneous chunk or result handshake.
REQ-030 SHALL ignore in_valid when in_ready=0; sigma and J_chunk are don't-care when in_valid=0.
REQ-031 SHALL, in simulation, $fatal on parameter violations: LANES not a power of two, LANES not dividing VECTOR_SIZE, or VECTOR_SIZE < 2.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force state=ACCUM, accumulator=0, chunk_idx=0, tree valid bits=0 and tree data registers=0.
REQ-033 SHALL drive these output values during reset: in_ready=1, res_valid=0, dot_out=0, chunk_idx=0.
REQ-034 SHALL treat reset mid-vector as discarding the partial sum; the first chunk accepted after reset is chunk 0.

Structure
REQ-035 SHALL place in shared package dot_pkg:
- the FSM state enum;
- the width helper functions for term width, tree width and accumulator width.
REQ-036 SHALL implement the lane reduction as sub-module dot_lane_tree (terms, tree, PIPE_STAGE_MASK registers, valid pipeline), built from the existing adder_tree_layer.
REQ-037 SHALL use the codebase FF register macro for all flops.

Verification
REQ-038 SHALL cover: VECTOR_SIZE=8, LANES=4, Jw=4, unsigned, mask=0; two chunks with all J=15, sigma all 1 -> dot_out=120, res_valid 1 cycle after the 2nd handshake.
REQ-039 SHALL cover: same configuration, sigma all 0 -> -120; alternating sigma with J=k -> (0-1)+(2-3)+(4-5)+(6-7) = -4.
REQ-040 SHALL cover: J_SIGNED=1, all J=-8, sigma all 0 -> +64; sigma all 1 -> -64.
REQ-041 SHALL cover: mask=2'b11 (P=2), in_valid held high -> res_valid 3 cycles after the last handshake; res_ready held low 5 cycles -> in_ready=0 and dot_out stable throughout; the next vector is accepted the cycle after res_ready.
REQ-042 SHALL cover: flush after chunk 0 of a vector -> chunk_idx=0; a subsequent full vector of J=1 with sigma all 1 -> 8, with no residue from the aborted vector.
REQ-043 SHALL cover: rst_n pulsed low asynchronously mid-DRAIN -> outputs immediately take their reset values; the next vector result is correct.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared FSM state, width helpers and the flop macro for the folded dot-product slice.
// Latency: none (declarations only); backpressure: not applicable.
`ifndef DOT_FF_MACRO
`define DOT_FF_MACRO
`define DOT_FF(q, d, rst_val) \
    always_ff @(posedge clk or negedge rst_n) begin \
        if (!rst_n) q <= (rst_val); \
        else        q <= (d); \
    end
`endif

package dot_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } dot_state_t;

    function automatic int term_width(input int jw);
        return jw + 1;
    endfunction

    function automatic int tree_width(input int jw, input int lanes);
        return jw + 1 + $clog2(lanes);
    endfunction

    function automatic int acc_width(input int jw, input int vsize);
        return jw + 1 + $clog2(vsize);
    endfunction

endpackage

// File: rtl/adder_tree_layer.sv
// One layer of a signed pairwise adder tree: N_IN operands in, N_IN/2 sums one bit wider out.
// Latency: combinational; backpressure: none.
module adder_tree_layer #(
    parameter int N_IN = 2,
    parameter int IN_W = 5
) (
    input  logic [N_IN*IN_W-1:0]         in_dat,
    output logic [(N_IN/2)*(IN_W+1)-1:0] out_dat
);

    for (genvar i = 0; i < N_IN / 2; i++) begin : g_pair
        logic signed [IN_W-1:0] a_dat;
        logic signed [IN_W-1:0] b_dat;
        assign a_dat = in_dat[(2*i)*IN_W +: IN_W];
        assign b_dat = in_dat[(2*i+1)*IN_W +: IN_W];
        assign out_dat[i*(IN_W+1) +: IN_W+1] = (IN_W+1)'(a_dat) + (IN_W+1)'(b_dat);
    end

endmodule

// File: rtl/dot_lane_tree.sv
// Forms +/-J terms for one chunk and reduces them exactly through an optionally registered tree.
// Latency: popcount(PIPE_STAGE_MASK) cycles; backpressure: none, the tree never stalls.
module dot_lane_tree
    import dot_pkg::*;
#(
    parameter int                         LANES           = 16,
    parameter int                         J_ELEMENT_WIDTH = 4,
    parameter int                         J_SIGNED        = 0,
    parameter logic [$clog2(LANES)-1:0]   PIPE_STAGE_MASK = '0
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                flush,
    input  logic                                                chunk_vld,
    input  logic [LANES-1:0]                                    sigma,
    input  logic [J_ELEMENT_WIDTH-1:0]                          j_dat [0:LANES-1],
    output logic                                                sum_vld,
    output logic signed [tree_width(J_ELEMENT_WIDTH, LANES)-1:0] sum_dat
);

    localparam int W0 = term_width(J_ELEMENT_WIDTH);
    localparam int L  = $clog2(LANES);
    localparam int TW = tree_width(J_ELEMENT_WIDTH, LANES);
    localparam int P  = $countones(PIPE_STAGE_MASK);

    // Bit offset of layer l's output inside the packed stage vector.
    function automatic int stage_off(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) o += (LANES >> (k + 1)) * (W0 + k + 1);
        return o;
    endfunction

    localparam int TOT = stage_off(L);

    logic [LANES*W0-1:0] terms;
    logic [TOT-1:0]      stage_dat;
    logic [L-1:0]        stage_vld;

    for (genvar n = 0; n < LANES; n++) begin : g_term
        logic signed [W0-1:0] ext;
        if (J_SIGNED != 0) begin : g_sext
            assign ext = {j_dat[n][J_ELEMENT_WIDTH-1], j_dat[n]};
        end else begin : g_zext
            assign ext = {1'b0, j_dat[n]};
        end
        // One spare bit makes -(-2^(Jw-1)) representable.
        assign terms[n*W0 +: W0] = sigma[n] ? ext : -ext;
    end

    for (genvar l = 0; l < L; l++) begin : g_layer
        localparam int N  = LANES >> l;
        localparam int W  = W0 + l;
        localparam int NO = N / 2;
        localparam int OW = W + 1;

        logic [N*W-1:0]   lin_dat;
        logic             lin_vld;
        logic [NO*OW-1:0] sum_l;
        logic [NO*OW-1:0] q_dat;
        logic             q_vld;

        if (l == 0) begin : g_src
            assign lin_dat = terms;
            assign lin_vld = chunk_vld;
        end else begin : g_src
            assign lin_dat = stage_dat[stage_off(l-1) +: N*W];
            assign lin_vld = stage_vld[l-1];
        end

        adder_tree_layer #(.N_IN(N), .IN_W(W)) u_layer (
            .in_dat  (lin_dat),
            .out_dat (sum_l)
        );

        if (PIPE_STAGE_MASK[l]) begin : g_reg
            `DOT_FF(q_dat, sum_l, '0)
            `DOT_FF(q_vld, lin_vld & ~flush, 1'b0)
        end else begin : g_comb
            assign q_dat = sum_l;
            assign q_vld = lin_vld;
        end

        assign stage_dat[stage_off(l) +: NO*OW] = q_dat;
        assign stage_vld[l]                     = q_vld;
    end

    // With no registered layer the clock, reset and flush have no load.
    if (P == 0) begin : g_no_regs
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, flush};
    end

    assign sum_dat = stage_dat[stage_off(L-1) +: TW];
    assign sum_vld = stage_vld[L-1];

endmodule

// File: rtl/folded_dot_product.sv
// Folds a VECTOR_SIZE-element +/-J dot product over LANES-wide chunks into one exact sum.
// Latency: result P+1 cycles after the last chunk; backpressure: in_ready drops from last chunk until res_ready.
module folded_dot_product
    import dot_pkg::*;
#(
    parameter int                        VECTOR_SIZE     = 256,
    parameter int                        LANES           = 16,
    parameter int                        J_ELEMENT_WIDTH = 4,
    parameter int                        J_SIGNED        = 0,
    parameter logic [$clog2(LANES)-1:0]  PIPE_STAGE_MASK = '0,
    parameter int                        RESULT_WIDTH    = (J_ELEMENT_WIDTH + 1) + $clog2(VECTOR_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES-1:0]                  sigma,
    input  logic [J_ELEMENT_WIDTH-1:0]        J_chunk [0:LANES-1],
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic signed [RESULT_WIDTH-1:0]    dot_out,
    output logic [((VECTOR_SIZE/LANES) > 1 ? $clog2(VECTOR_SIZE/LANES) : 1)-1:0] chunk_idx
);

    localparam int NCH = VECTOR_SIZE / LANES;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = tree_width(J_ELEMENT_WIDTH, LANES);
    localparam int AW  = acc_width(J_ELEMENT_WIDTH, VECTOR_SIZE);
    localparam int P   = $countones(PIPE_STAGE_MASK);
    localparam int CW  = $clog2(LANES) + 1;

    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $fatal(1, "folded_dot_product: LANES must be a power of two >= 2");
    end
    if (VECTOR_SIZE < 2) begin : g_bad_vsize
        $fatal(1, "folded_dot_product: VECTOR_SIZE must be >= 2");
    end
    if ((VECTOR_SIZE % LANES) != 0) begin : g_bad_div
        $fatal(1, "folded_dot_product: LANES must divide VECTOR_SIZE");
    end
    if (RESULT_WIDTH < AW) begin : g_narrow
        $error("folded_dot_product: RESULT_WIDTH is narrower than the exact sum width");
    end

    dot_state_t          state, state_nxt;
    logic signed [AW-1:0] acc, acc_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [CW-1:0]       drain_cnt, drain_nxt;
    logic                accept;
    logic                last_chunk;
    logic                sum_vld;
    logic signed [TW-1:0] sum_dat;

    assign accept     = in_valid && (state == ST_ACCUM);
    assign last_chunk = (idx == IW'(NCH - 1));

    dot_lane_tree #(
        .LANES           (LANES),
        .J_ELEMENT_WIDTH (J_ELEMENT_WIDTH),
        .J_SIGNED        (J_SIGNED),
        .PIPE_STAGE_MASK (PIPE_STAGE_MASK)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .chunk_vld (accept),
        .sigma     (sigma),
        .j_dat     (J_chunk),
        .sum_vld   (sum_vld),
        .sum_dat   (sum_dat)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        drain_nxt = drain_cnt;
        in_ready  = 1'b0;
        res_valid = 1'b0;

        if (sum_vld) acc_nxt = acc + AW'(sum_dat);

        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    idx_nxt = last_chunk ? '0 : idx + 1'b1;
                    if (last_chunk) begin
                        if (P == 0) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_DRAIN;
                            drain_nxt = CW'(P);
                        end
                    end
                end
            end
            // The last chunk leaves the tree exactly P edges after its handshake.
            ST_DRAIN: begin
                drain_nxt = drain_cnt - 1'b1;
                if (drain_cnt == CW'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_ACCUM;
                    acc_nxt   = '0;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase

        if (flush) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = '0;
            idx_nxt   = '0;
            drain_nxt = '0;
        end
    end

    `DOT_FF(state, state_nxt, ST_ACCUM)
    `DOT_FF(acc, acc_nxt, '0)
    `DOT_FF(idx, idx_nxt, '0)
    `DOT_FF(drain_cnt, drain_nxt, '0)

    assign dot_out   = RESULT_WIDTH'(acc);
    assign chunk_idx = idx;

endmodule

// File: tb/tb_folded_dot_product.sv
// Scoreboard bench: three 8-element, 4-lane instances (unsigned comb, signed comb, unsigned P=2).
module tb_folded_dot_product;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush     [3];
    logic              in_valid  [3];
    logic              in_ready  [3];
    logic [3:0]        sigma_in  [3];
    logic [3:0]        jc        [3][0:3];
    logic              res_valid [3];
    logic              res_ready [3];
    logic signed [7:0] dot_out   [3];
    logic [0:0]        cidx      [3];

    logic [3:0] vj [0:1][0:3];
    logic [3:0] vs [0:1];
    int         exp_q [3][$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        folded_dot_product #(
            .VECTOR_SIZE     (8),
            .LANES           (4),
            .J_ELEMENT_WIDTH (4),
            .J_SIGNED        ((g == 1) ? 1 : 0),
            .PIPE_STAGE_MASK ((g == 2) ? 2'b11 : 2'b00)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .sigma     (sigma_in[g]),
            .J_chunk   (jc[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .dot_out   (dot_out[g]),
            .chunk_idx (cidx[g])
        );
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int d);
        int s;
        int e;
        s = 0;
        for (int c = 0; c < 2; c++)
            for (int l = 0; l < 4; l++) begin
                e = (d == 1) ? int'($signed(vj[c][l])) : int'(vj[c][l]);
                s += vs[c][l] ? e : -e;
            end
        return s;
    endfunction

    task automatic fill(input logic [3:0] j, input logic [3:0] s);
        for (int c = 0; c < 2; c++) begin
            vs[c] = s;
            for (int l = 0; l < 4; l++) vj[c][l] = j;
        end
    endtask

    task automatic fill_ramp();
        for (int c = 0; c < 2; c++) begin
            vs[c] = 4'b0101;
            for (int l = 0; l < 4; l++) vj[c][l] = 4'(c * 4 + l);
        end
    endtask

    // Called and returns at a negedge; the handshake falls on the posedge in between.
    task automatic send_chunk(input int d, input int c);
        int t;
        in_valid[d] = 1'b1;
        sigma_in[d] = vs[c];
        jc[d]       = vj[c];
        t = 0;
        while (!in_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk($sformatf("dut%0d accept timeout", d), 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_res(input int d, output int lat);
        in_valid[d] = 1'b0;
        lat = 1;
        while (!res_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input int d, input int exp, input int p);
        int lat;
        send_chunk(d, 0);
        send_chunk(d, 1);
        exp_q[d].push_back(exp);
        wait_res(d, lat);
        chk($sformatf("dut%0d latency", d), lat, p + 1);
        @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (rst_n && !flush[d] && res_valid[d] && res_ready[d]) begin
                if (exp_q[d].size() == 0) chk($sformatf("dut%0d unexpected result", d), dot_out[d], 9999);
                else chk($sformatf("dut%0d result", d), dot_out[d], exp_q[d].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; res_ready[d] = 1'b1; sigma_in[d] = '0;
            for (int l = 0; l < 4; l++) jc[d][l] = '0;
        end
        #3;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset in_ready", d), in_ready[d], 1);
            chk($sformatf("dut%0d reset res_valid", d), res_valid[d], 0);
            chk($sformatf("dut%0d reset dot_out", d), dot_out[d], 0);
            chk($sformatf("dut%0d reset chunk_idx", d), cidx[d], 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill(4'd15, 4'hF); run_vec(0, 120, 0);
        fill(4'd15, 4'h0); run_vec(0, -120, 0);
        fill_ramp();       run_vec(0, -4, 0);

        fill(4'b1000, 4'h0); run_vec(1, 64, 0);
        fill(4'b1000, 4'hF); run_vec(1, -64, 0);

        // Pipelined instance: result held while res_ready is low.
        res_ready[2] = 1'b0;
        fill(4'd15, 4'hF);
        send_chunk(2, 0);
        send_chunk(2, 1);
        exp_q[2].push_back(120);
        wait_res(2, lat);
        chk("dut2 latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("dut2 hold in_ready", in_ready[2], 0);
            chk("dut2 hold res_valid", res_valid[2], 1);
            chk("dut2 hold dot_out", dot_out[2], 120);
            @(negedge clk);
        end
        fill_ramp();
        res_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        sigma_in[2]  = vs[0];
        jc[2]        = vj[0];
        @(negedge clk);
        chk("dut2 ready after release", in_ready[2], 1);
        chk("dut2 idx after release", cidx[2], 0);
        send_chunk(2, 0);
        chk("dut2 idx after chunk0", cidx[2], 1);
        send_chunk(2, 1);
        exp_q[2].push_back(-4);
        wait_res(2, lat);
        chk("dut2 latency 2nd", lat, 3);
        @(negedge clk);

        // Flush after chunk 0, with a chunk still offered on the flush edge.
        fill(4'd15, 4'hF);
        send_chunk(0, 0);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        chk("dut0 idx after flush", cidx[0], 0);
        chk("dut0 dot_out after flush", dot_out[0], 0);
        fill(4'd1, 4'hF); run_vec(0, 8, 0);

        // Asynchronous reset while the pipelined instance is draining.
        fill(4'd15, 4'hF);
        send_chunk(2, 0);
        send_chunk(2, 1);
        chk("dut2 in DRAIN", in_ready[2], 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("dut2 async in_ready", in_ready[2], 1);
        chk("dut2 async res_valid", res_valid[2], 0);
        chk("dut2 async dot_out", dot_out[2], 0);
        chk("dut2 async chunk_idx", cidx[2], 0);
        in_valid[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill(4'd1, 4'hF); run_vec(2, 8, 2);

        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 4; i++) begin
                for (int c = 0; c < 2; c++) begin
                    vs[c] = 4'($urandom_range(0, 15));
                    for (int l = 0; l < 4; l++) vj[c][l] = 4'($urandom_range(0, 15));
                end
                run_vec(d, model(d), (d == 2) ? 2 : 0);
            end

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("dut%0d leftover", d), exp_q[d].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
